// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg
//   Shared definitions for the clock-gating enable controller:
//   FSM state encoding (Gray order, so adjacent states differ in one bit),
//   timer width, and the saturation value of the optional wake counter.
package clk_gate_pkg;

  localparam logic [1:0] ST_OFF_ENC  = 2'b00;
  localparam logic [1:0] ST_WAKE_ENC = 2'b01;
  localparam logic [1:0] ST_ON_ENC   = 2'b11;
  localparam logic [1:0] ST_HOLD_ENC = 2'b10;

  typedef enum logic [1:0] {
    CG_OFF  = ST_OFF_ENC,
    CG_WAKE = ST_WAKE_ENC,
    CG_ON   = ST_ON_ENC,
    CG_HOLD = ST_HOLD_ENC
  } cg_state_e;

  localparam int unsigned TIMER_W = 8;

  localparam logic [7:0] WAKE_CNT_SAT = 8'd255;

  // Saturating increment used by the wake statistics counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == WAKE_CNT_SAT) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/cg_timer.sv
// cg_timer
//   Loadable down-counter used by the clock-gate controller for both the
//   wake and idle intervals. Load has priority over decrement; the counter
//   stops at zero instead of wrapping.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset (count clears to 0)
//   load_i     load load_val_i on the next edge
//   load_val_i value to load
//   dec_i      decrement on the next edge (ignored while loading)
//   is_one_o   current count equals 1
module cg_timer
  import clk_gate_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               is_one_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_one_o = (count_q == TIMER_W'(1));

endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
//   Drives the enable of the system clock gate. A request wakes the gated
//   clock; READY follows after WAKE_CYCLES cycles. Once REQ and BUSY have
//   both been low long enough (IDLE_CYCLES after entering HOLD) the clock is
//   gated off again. Outputs are registered so CLK_EN only changes after a
//   rising CLK edge and is stable while the gate latch is transparent.
//
//   Optional macro CLK_GATE_WAKE_STATS_EN adds WAKE_COUNT, a saturating
//   count of OFF->WAKE transitions, cleared only by reset.
//
// Parameters:
//   WAKE_CYCLES  cycles from CLK_EN rising to READY rising (1..255)
//   IDLE_CYCLES  idle cycles in HOLD before CLK_EN drops (1..255)
// Ports:
//   CLK          free-running system clock
//   RST          asynchronous active-low reset
//   REQ          requester wants the gated clock (level)
//   BUSY         gated block still working
//   CLK_EN       enable to the clock gate
//   READY        gated clock running and stable
//   WAKE_COUNT   saturating OFF->WAKE count (macro builds only)
//
// state | meaning
// ------+--------------------------------------------------------------
// OFF   | gated clock stopped; waits for REQ
// WAKE  | clock enabled, counting down WAKE_CYCLES before READY
// ON    | clock running, READY high; waits for REQ=0 and BUSY=0
// HOLD  | idle countdown; any REQ/BUSY returns to ON, expiry goes OFF
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic       BUSY,
  output logic       CLK_EN,
  output logic       READY
`ifdef CLK_GATE_WAKE_STATS_EN
  ,
  output logic [7:0] WAKE_COUNT
`endif
);

  localparam logic [TIMER_W-1:0] WAKE_LOAD = TIMER_W'(WAKE_CYCLES);
  localparam logic [TIMER_W-1:0] IDLE_LOAD = TIMER_W'(IDLE_CYCLES);

  cg_state_e          state_q;
  cg_state_e          state_d;
  logic               clk_en_q;
  logic               clk_en_d;
  logic               ready_q;
  logic               ready_d;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               tmr_dec;
  logic               tmr_is_one;

  cg_timer u_timer (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .is_one_o   (tmr_is_one)
  );

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    unique case (state_q)
      CG_OFF: begin
        if (REQ) begin
          tmr_load     = 1'b1;
          tmr_load_val = WAKE_LOAD;
          state_d      = CG_WAKE;
        end
      end
      CG_WAKE: begin
        // REQ is ignored here: a started wake always runs to completion.
        tmr_dec = 1'b1;
        if (tmr_is_one) begin
          state_d = CG_ON;
        end
      end
      CG_ON: begin
        if (!REQ && !BUSY) begin
          tmr_load     = 1'b1;
          tmr_load_val = IDLE_LOAD;
          state_d      = CG_HOLD;
        end
      end
      CG_HOLD: begin
        // Activity beats expiry, even in the last idle cycle.
        if (REQ || BUSY) begin
          state_d = CG_ON;
        end else begin
          tmr_dec = 1'b1;
          if (tmr_is_one) begin
            state_d = CG_OFF;
          end
        end
      end
      default: state_d = CG_OFF;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change
  // in the same cycle as the state they describe.
  always_comb begin
    clk_en_d = (state_d != CG_OFF);
    ready_d  = (state_d == CG_ON) || (state_d == CG_HOLD);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= CG_OFF;
      clk_en_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_en_q <= clk_en_d;
      ready_q  <= ready_d;
    end
  end

  assign CLK_EN = clk_en_q;
  assign READY  = ready_q;

`ifdef CLK_GATE_WAKE_STATS_EN
  logic [7:0] wake_cnt_q;
  logic [7:0] wake_cnt_d;

  always_comb begin
    wake_cnt_d = wake_cnt_q;
    if ((state_q == CG_OFF) && (state_d == CG_WAKE)) begin
      wake_cnt_d = sat_inc8(wake_cnt_q);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wake_cnt_q <= '0;
    end else begin
      wake_cnt_q <= wake_cnt_d;
    end
  end

  assign WAKE_COUNT = wake_cnt_q;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Testbench for clk_gate_ctrl (default parameters). Expected outputs come
// from a cycle-level behavioural model that counts wake cycles and
// consecutive idle samples; a monitor compares them against the DUT.
module tb_clk_gate_ctrl;

  localparam int W = 2;
  localparam int I = 4;

  logic CLK  = 1'b0;
  logic RST  = 1'b0;
  logic REQ  = 1'b0;
  logic BUSY = 1'b0;
  logic CLK_EN;
  logic READY;
`ifdef CLK_GATE_WAKE_STATS_EN
  logic [7:0] WAKE_COUNT;
`endif

  always #5 CLK = ~CLK;

  clk_gate_ctrl #(
    .WAKE_CYCLES (W),
    .IDLE_CYCLES (I)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ        (REQ),
    .BUSY       (BUSY),
    .CLK_EN     (CLK_EN),
    .READY      (READY)
`ifdef CLK_GATE_WAKE_STATS_EN
    ,
    .WAKE_COUNT (WAKE_COUNT)
`endif
  );

  typedef struct {
    bit en;
    bit rdy;
    int wc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_en  = 1'b0;

  // Reference model state: clock enabled, ready, wake cycles still to run,
  // consecutive idle samples seen while ready, wakes counted (saturating).
  bit m_en;
  bit m_rdy;
  int m_wake_left;
  int m_idle_run;
  int m_wakes;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    if (!sb_en) begin
      m_en = 0; m_rdy = 0; m_wake_left = 0; m_idle_run = 0; m_wakes = 0;
    end else begin
      if (!m_en) begin
        if (REQ) begin
          m_en = 1;
          m_wake_left = W;
          if (m_wakes < 255) m_wakes++;
        end
      end else if (!m_rdy) begin
        m_wake_left--;
        if (m_wake_left == 0) begin
          m_rdy = 1;
          m_idle_run = 0;
        end
      end else if (!REQ && !BUSY) begin
        m_idle_run++;
        // Idle sample that enters HOLD plus I countdown samples.
        if (m_idle_run > I) begin
          m_en = 0;
          m_rdy = 0;
        end
      end else begin
        m_idle_run = 0;
      end
      e.en  = m_en;
      e.rdy = m_rdy;
      e.wc  = m_wakes;
      sb_q.push_back(e);
    end
  endtask

  always @(posedge CLK) model_step();

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("clk_en", int'(CLK_EN), int'(e.en));
      chk("ready", int'(READY), int'(e.rdy));
`ifdef CLK_GATE_WAKE_STATS_EN
      chk("wake_count", int'(WAKE_COUNT), e.wc);
`endif
    end
  end

  task automatic cyc(input bit r, input bit b, input int n);
    repeat (n) begin
      @(negedge CLK);
      REQ  = r;
      BUSY = b;
    end
  endtask

  // Pulls reset low mid-cycle and checks the outputs drop without an edge.
  task automatic async_reset(input string nm);
    @(negedge CLK);
    chk({nm, "_pre_en"}, int'(CLK_EN), 1);
    sb_en = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk({nm, "_en"}, int'(CLK_EN), 0);
    chk({nm, "_rdy"}, int'(READY), 0);
`ifdef CLK_GATE_WAKE_STATS_EN
    chk({nm, "_wc"}, int'(WAKE_COUNT), 0);
`endif
    REQ  = 1'b0;
    BUSY = 1'b0;
    repeat (2) @(negedge CLK);
    RST   = 1'b1;
    sb_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_en", int'(CLK_EN), 0);
    chk("reset_rdy", int'(READY), 0);
    RST   = 1'b1;
    sb_en = 1'b1;

    // Idle, then BUSY alone must not wake.
    cyc(0, 0, 10);
    cyc(0, 1, 10);
    cyc(0, 0, 2);

    // Plain request/release with defaults.
    cyc(1, 0, 7);
    cyc(0, 0, 10);

    // BUSY pulse in the last HOLD cycle keeps the clock on.
    cyc(1, 0, 3);
    cyc(0, 0, 4);
    cyc(0, 1, 1);
    cyc(0, 0, 8);

    // One-cycle REQ pulse: wake completes, then release.
    cyc(1, 0, 1);
    cyc(0, 0, 10);

    // Reset mid-WAKE, then a full new wake.
    cyc(1, 0, 1);
    async_reset("rst_wake");
    cyc(1, 0, 4);
    cyc(0, 0, 10);

    // Reset mid-HOLD, then a full new wake.
    cyc(1, 0, 1);
    cyc(0, 0, 3);
    async_reset("rst_hold");
    cyc(1, 0, 3);
    cyc(0, 0, 10);

    // Random traffic.
    repeat (300) begin
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
          int'($urandom_range(1, 8)));
    end
    cyc(0, 0, 8);

    // Many wake/release cycles to drive the wake counter into saturation.
    repeat (300) begin
      cyc(1, 0, 1);
      cyc(0, 0, 8);
    end
`ifdef CLK_GATE_WAKE_STATS_EN
    @(negedge CLK);
    chk("wake_sat", int'(WAKE_COUNT), 255);
`endif

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
